// File: rtl/uart_pkg.sv
// Shared UART frame constants and state encoding for the transmitter and receiver.
// UART_TX_PARITY_EN adds the PARITY state between DATA and STOP.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 9600;
  localparam int unsigned DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CNT_MAX-1 while enabled, pulses tc on the last count.
// Holds at zero whenever disabled so every frame starts on a full bit.
module uart_baud_gen #(
  parameter int unsigned CNT_MAX = 5208
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc    = en && (cnt_q == CNT_W'(CNT_MAX - 1));
    cnt_d = cnt_q;
    if (!en || tc) cnt_d = '0;
    else           cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; tx, tx_busy and tx_done are all flop outputs.
// Define UART_TX_PARITY_EN for an extra parity bit (even, or odd with PARITY_ODD=1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in_data,
  input  logic       in_flag,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  // Derived, not a parameter, so it always tracks CLK_FREQ/BAUD.
  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / BAUD;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_tc;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_baud_gen #(
    .CNT_MAX(BAUD_CNT_MAX)
  ) u_baud_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (state_q != ST_IDLE),
    .tc       (bit_tc)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_flag) begin
          shift_d   = in_data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^in_data) ^ PARITY_ODD;
`endif
        end
      end
      ST_START: begin
        if (bit_tc) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      // tx is registered, so it loads the bit the shifted register will expose next.
      ST_DATA: begin
        if (bit_tc) begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tc) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tc) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at a scaled baud (16 clocks per bit).
// Each cycle's {tx, tx_busy, tx_done} is compared with a frame-level line model.
module tb_uart_tx;

  localparam int unsigned CLK_FREQ = 160;
  localparam int unsigned BAUD     = 10;
  localparam int unsigned N        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam bit          PODD     = 1'b0;
  localparam int unsigned NB       = 11;
`else
  localparam int unsigned NB       = 10;
`endif
  localparam int unsigned F        = NB * N;
  localparam int unsigned EXP_SZ   = 1024;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       in_flag   = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       tx, tx_busy, tx_done;

  int passed = 0;
  int total  = 0;

  logic [2:0] obs[$];
  logic [2:0] expv[EXP_SZ];

  uart_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(PODD)
`endif
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .in_data  (in_data),
    .in_flag  (in_flag),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference line model: idle is {tx=1,busy=0,done=0}.
  task automatic clear_exp();
    for (int i = 0; i < EXP_SZ; i++) expv[i] = 3'b100;
  endtask

  // A frame accepted so that sample s shows the start bit; done appears at s+F.
  task automatic add_frame(input logic [7:0] b, input int s);
    for (int j = 0; j < int'(F); j++) begin
      int   idx;
      logic line;
      idx = j / int'(N);
      if (idx == 0)      line = 1'b0;
      else if (idx <= 8) line = b[idx-1];
`ifdef UART_TX_PARITY_EN
      else if (idx == 9) line = (^b) ^ PODD;
`endif
      else               line = 1'b1;
      expv[s+j] = {line, 1'b1, 1'b0};
    end
    expv[s+int'(F)] = 3'b101;
  endtask

  // Samples n cycles at edge+1; optionally pulses in_flag with inj_byte after sample inj_at.
  task automatic capture(input int n, input int inj_at, input logic [7:0] inj_byte);
    obs.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      if (i == 0) begin
        in_flag = 1'b0;
        in_data = 8'($urandom);
      end
      obs.push_back({tx, tx_busy, tx_done});
      if (i == inj_at) begin
        in_flag = 1'b1;
        in_data = inj_byte;
      end else if (inj_at >= 0 && i == inj_at + 1) begin
        in_flag = 1'b0;
        in_data = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    #23;
    total++;
    if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else passed++;
    total++;
    if (tx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", tx_busy); else passed++;
    total++;
    if (tx_done !== 1'b0) $display("FAIL reset_done got %b want 0", tx_done); else passed++;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    clear_exp();
    capture(4, -1, 8'h00);
    for (int k = 0; k < obs.size(); k++) begin
      total++;
      if (obs[k] !== expv[k])
        $display("FAIL post_reset_idle k=%0d got {tx,busy,done}=%b want %b", k, obs[k], expv[k]);
      else passed++;
    end
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    clear_exp();
    add_frame(b, 0);
    in_flag = 1'b1;
    in_data = b;
    capture(int'(F) + 3, -1, 8'h00);
    for (int k = 0; k < obs.size(); k++) begin
      total++;
      if (obs[k] !== expv[k])
        $display("FAIL frame_%02h k=%0d got {tx,busy,done}=%b want %b", b, k, obs[k], expv[k]);
      else passed++;
    end
  endtask

  task automatic test_drop_while_busy(input logic [7:0] a, input logic [7:0] b, input int at);
    clear_exp();
    add_frame(a, 0);
    in_flag = 1'b1;
    in_data = a;
    capture(int'(F) + 4, at, b);
    for (int k = 0; k < obs.size(); k++) begin
      total++;
      if (obs[k] !== expv[k])
        $display("FAIL drop_%02h_%02h k=%0d got {tx,busy,done}=%b want %b", a, b, k, obs[k], expv[k]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b);
    clear_exp();
    add_frame(a, 0);
    add_frame(b, int'(F) + 1);
    in_flag = 1'b1;
    in_data = a;
    capture(2 * int'(F) + 4, int'(F), b);
    for (int k = 0; k < obs.size(); k++) begin
      total++;
      if (obs[k] !== expv[k])
        $display("FAIL b2b_%02h_%02h k=%0d got {tx,busy,done}=%b want %b", a, b, k, obs[k], expv[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_frame(input logic [7:0] b);
    int cut;
    cut = 5 * int'(N) + int'(N) / 2;
    clear_exp();
    add_frame(b, 0);
    in_flag = 1'b1;
    in_data = b;
    capture(cut, -1, 8'h00);
    for (int k = 0; k < obs.size(); k++) begin
      total++;
      if (obs[k] !== expv[k])
        $display("FAIL pre_abort k=%0d got {tx,busy,done}=%b want %b", k, obs[k], expv[k]);
      else passed++;
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    total++;
    if ({tx, tx_busy, tx_done} !== 3'b100)
      $display("FAIL async_abort got {tx,busy,done}=%b want 100", {tx, tx_busy, tx_done});
    else passed++;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    clear_exp();
    capture(int'(F), -1, 8'h00);
    for (int k = 0; k < obs.size(); k++) begin
      total++;
      if (obs[k] !== expv[k])
        $display("FAIL post_abort_idle k=%0d got {tx,busy,done}=%b want %b", k, obs[k], expv[k]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame(8'h55);
    test_single_frame(8'h07);
    for (int r = 0; r < 4; r++) test_single_frame(8'($urandom));
    test_drop_while_busy(8'h12, 8'hFF, 2 * int'(N) + 3);
    test_drop_while_busy(8'($urandom), 8'($urandom), int'($urandom_range(0, F - 2)));
    test_back_to_back(8'h55, 8'h3C);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_reset_mid_frame(8'($urandom));
    test_single_frame(8'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
